keep_to_cnt_sync: RTL and testbench
===================================

Name: keep_to_cnt_sync

Overview:
Converts the byte-enable (keep) field of one 73-bit receive FIFO word into a byte count. The word format is bit 72 = end-of-frame, bits 71:64 = keep (one bit per data byte, bit 64 = byte 0), and bits 63:0 = data. The block sits between the receive data FIFO read port and the frame byte-count accumulator in the S2MM output path. It is a single-stage registered converter. It also flags keep patterns that are not contiguous from byte 0.

Parameters:
C_WORD_W, 73, total FIFO word width.
C_KEEP_LSB, 64, bit position of keep bit 0 within the word.
C_KEEP_W, 8, number of keep bits (bytes per word).
C_CNT_W, 4, count width; must satisfy 2^C_CNT_W > C_KEEP_W.

Ports:
clk  in  1  single clock for all logic.
rst  in  1  asynchronous, active-high reset.
keep  in  C_WORD_W  FIFO word; only the keep field and bit C_WORD_W-1 (EOF) are used.
keep_valid  in  1  qualifies keep this cycle.
cnt  out  C_CNT_W  number of set keep bits, registered.
cnt_valid  out  1  cnt, cnt_last and keep_err are valid this cycle.
cnt_last  out  1  registered copy of keep[C_WORD_W-1].
keep_err  out  1  set when the keep field is not of the form 2^n-1, 0<=n<=C_KEEP_W.

Behaviour:
- Reset (rst=1, asynchronous assert): cnt=0, cnt_valid=0, cnt_last=0, keep_err=0. Release is synchronous to clk; the first capture happens on the first rising edge with rst=0.
- Latency: fixed one cycle. Inputs sampled on rising edge N appear on the outputs after edge N. No backpressure; a new word is accepted every cycle.
- cnt = popcount of keep[C_KEEP_LSB+C_KEEP_W-1 : C_KEEP_LSB]. Range 0..C_KEEP_W, zero-extended to C_CNT_W. No saturation or wrap is possible under the parameter constraint.
- Popcount is used for every pattern, contiguous or not. For example, keep=8'b1010_0101 gives cnt=4 with keep_err=1.
- keep_err=1 when the keep field has a 0 below any 1. All-zero (n=0) and all-ones are legal (keep_err=0).
- cnt_valid is a registered copy of keep_valid.
- cnt and keep_err register on every edge regardless of keep_valid, so a consumer may sample cnt one cycle after a FIFO read without a qualifier.
- cnt_last registers only when keep_valid=1; otherwise it holds its previous value.
- Data bits 63:0 are ignored.
- Reset asserted mid-stream clears all outputs in the same cycle. No partial state survives.
- No internal state beyond the output registers; back-to-back words are independent.

Test Plan:
1. Reset: hold rst=1 with keep field 8'hFF and keep_valid=1 -> cnt=0, cnt_valid=0, keep_err=0, cnt_last=0 throughout. Release rst -> next cycle cnt=8, cnt_valid=1.
2. Contiguous sweep: drive keep field 8'h00, 01, 03, 07, 0F, 1F, 3F, 7F, FF on consecutive cycles with keep_valid=1 -> cnt=0,1,...,8 one cycle later each; keep_err=0 on every cycle.
3. Non-contiguous: keep field 8'hA5 -> cnt=4, keep_err=1. Keep field 8'h80 -> cnt=1, keep_err=1. Keep field 8'hFE -> cnt=7, keep_err=1.
4. EOF: word with bit72=1 and keep field 8'h07, keep_valid=1 -> cnt=3, cnt_last=1. Next cycle keep_valid=0 with bit72=0 -> cnt_valid=0, cnt_last stays 1.
5. Mid-stream reset: stream keep field 8'hFF each cycle and assert rst asynchronously between edges -> outputs drop to 0 immediately, not waiting for an edge. After release, counting resumes with cnt=8 one edge later.
6. Throughput: 16 back-to-back random keep values -> each cnt equals the popcount of the word presented exactly one cycle earlier, with no gaps in cnt_valid.

Source files
------------

// File: rtl/keep_to_cnt_sync.sv
// Registered keep-to-byte-count converter for 73-bit receive FIFO words.
// Reports the popcount of the keep field and flags keep patterns that are not contiguous from byte 0.
module keep_to_cnt_sync #(
  parameter int C_WORD_W   = 73,
  parameter int C_KEEP_LSB = 64,
  parameter int C_KEEP_W   = 8,
  parameter int C_CNT_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [C_WORD_W-1:0] keep,
  input  logic                keep_valid,
  output logic [C_CNT_W-1:0]  cnt,
  output logic                cnt_valid,
  output logic                cnt_last,
  output logic                keep_err
);

  function automatic logic [C_CNT_W-1:0] popcount(input logic [C_KEEP_W-1:0] k);
    logic [C_CNT_W-1:0] c;
    c = {C_CNT_W{1'b0}};
    for (int i = 0; i < C_KEEP_W; i++) begin
      c = c + {{(C_CNT_W-1){1'b0}}, k[i]};
    end
    return c;
  endfunction

  // A 2^n-1 pattern shares no set bit with itself plus one; all-ones wraps to zero.
  function automatic logic non_contig(input logic [C_KEEP_W-1:0] k);
    logic [C_KEEP_W-1:0] kp1;
    kp1 = k + {{(C_KEEP_W-1){1'b0}}, 1'b1};
    return |(k & kp1);
  endfunction

  logic [C_KEEP_W-1:0] keep_field_s;
  logic                data_unused_s;
  logic [C_CNT_W-1:0]  cnt_d, cnt_q;
  logic                err_d, err_q;
  logic                valid_d, valid_q;
  logic                last_d, last_q;

  assign keep_field_s  = keep[C_KEEP_LSB +: C_KEEP_W];
  assign data_unused_s = ^keep[C_KEEP_LSB-1:0];

  // Next-state computation for the output registers.
  always_comb begin
    cnt_d   = popcount(keep_field_s);
    err_d   = non_contig(keep_field_s);
    valid_d = keep_valid;
    if (keep_valid) begin
      last_d = keep[C_WORD_W-1];
    end else begin
      last_d = last_q;
    end
  end

  // Output registers; cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= {C_CNT_W{1'b0}};
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign cnt       = cnt_q;
  assign keep_err  = err_q;
  assign cnt_valid = valid_q;
  assign cnt_last  = last_q;

endmodule

// File: tb/tb_keep_to_cnt_sync.sv
// Directed, table-driven self-checking bench for keep_to_cnt_sync.
module tb_keep_to_cnt_sync;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [72:0] keep = '0;
  logic        keep_valid = 1'b0;
  logic [3:0]  cnt;
  logic        cnt_valid;
  logic        cnt_last;
  logic        keep_err;

  int checks = 0;
  int failures = 0;

  keep_to_cnt_sync dut (
    .clk        (clk),
    .rst        (rst),
    .keep       (keep),
    .keep_valid (keep_valid),
    .cnt        (cnt),
    .cnt_valid  (cnt_valid),
    .cnt_last   (cnt_last),
    .keep_err   (keep_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] kf;
    logic       eof;
    logic       v;
    logic [3:0] cnt;
    logic       err;
    logic       last;
  } vec_t;

  vec_t tbl [18];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input int c, input int v, input int l, input int e);
    check({tag, ".cnt"}, int'(cnt), c);
    check({tag, ".cnt_valid"}, int'(cnt_valid), v);
    check({tag, ".cnt_last"}, int'(cnt_last), l);
    check({tag, ".keep_err"}, int'(keep_err), e);
  endtask

  task automatic drive(input logic eof, input logic [7:0] kf, input logic v);
    keep = {eof, kf, $urandom(), $urandom()};
    keep_valid = v;
  endtask

  function automatic int ref_cnt(input logic [7:0] k);
    int n = 0;
    for (int i = 0; i < 8; i++) if (k[i]) n++;
    return n;
  endfunction

  function automatic int ref_err(input logic [7:0] k);
    for (int n = 0; n <= 8; n++) begin
      if (int'(k) == (1 << n) - 1) return 0;
    end
    return 1;
  endfunction

  initial begin
    tbl[0]  = '{8'h00, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0};
    tbl[1]  = '{8'h01, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0};
    tbl[2]  = '{8'h03, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0};
    tbl[3]  = '{8'h07, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0};
    tbl[4]  = '{8'h0F, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0};
    tbl[5]  = '{8'h1F, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0};
    tbl[6]  = '{8'h3F, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0};
    tbl[7]  = '{8'h7F, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0};
    tbl[8]  = '{8'hFF, 1'b0, 1'b1, 4'd8, 1'b0, 1'b0};
    tbl[9]  = '{8'hA5, 1'b0, 1'b1, 4'd4, 1'b1, 1'b0};
    tbl[10] = '{8'h80, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0};
    tbl[11] = '{8'hFE, 1'b0, 1'b1, 4'd7, 1'b1, 1'b0};
    tbl[12] = '{8'h07, 1'b1, 1'b1, 4'd3, 1'b0, 1'b1};
    tbl[13] = '{8'h07, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1};
    tbl[14] = '{8'h01, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1};
    tbl[15] = '{8'hA5, 1'b1, 1'b0, 4'd4, 1'b1, 1'b1};
    tbl[16] = '{8'h00, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0};
    tbl[17] = '{8'hA5, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0};

    // Reset held with an active all-ones word.
    drive(1'b1, 8'hFF, 1'b1);
    #1;
    check_all("reset_async", 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_all("reset_hold", 0, 0, 0, 0);
    end
    drive(1'b0, 8'hFF, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;
    check_all("reset_release", 8, 1, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].eof, tbl[i].kf, tbl[i].v);
      @(posedge clk); #1;
      check_all($sformatf("vec%0d", i), int'(tbl[i].cnt), int'(tbl[i].v),
                int'(tbl[i].last), int'(tbl[i].err));
    end

    // Mid-stream asynchronous reset.
    drive(1'b1, 8'hFF, 1'b1);
    @(posedge clk); #1;
    check_all("pre_rst", 8, 1, 1, 0);
    #2 rst = 1'b1;
    #1;
    check_all("mid_rst_async", 0, 0, 0, 0);
    @(posedge clk); #1;
    check_all("mid_rst_hold", 0, 0, 0, 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check_all("mid_rst_resume", 8, 1, 1, 0);

    // Back-to-back random words.
    for (int i = 0; i < 16; i++) begin
      logic [7:0] k;
      k = 8'($urandom());
      drive(1'b0, k, 1'b1);
      @(posedge clk); #1;
      check($sformatf("rand%0d.cnt", i), int'(cnt), ref_cnt(k));
      check($sformatf("rand%0d.err", i), int'(keep_err), ref_err(k));
      check($sformatf("rand%0d.valid", i), int'(cnt_valid), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
